// File: rtl/gpr_exec_unit.sv
// Clocked GPR-file execution unit: one instruction per handshake, single-cycle ALU ops,
// iterative shift-add multiply writing low half to rdst and high half to SGPR.
module gpr_exec_unit #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              done,
    output logic              err,
    output logic [3:0]        flags,
    output logic [DATA_W-1:0] sgpr,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(DATA_W);

    localparam logic [4:0] OP_MOVSGPR = 5'b00000;
    localparam logic [4:0] OP_MOV     = 5'b00001;
    localparam logic [4:0] OP_ADD     = 5'b00010;
    localparam logic [4:0] OP_SUB     = 5'b00011;
    localparam logic [4:0] OP_MUL     = 5'b00100;
    localparam logic [4:0] OP_OR      = 5'b00101;
    localparam logic [4:0] OP_AND     = 5'b00110;
    localparam logic [4:0] OP_XOR     = 5'b00111;
    localparam logic [4:0] OP_XNOR    = 5'b01000;
    localparam logic [4:0] OP_NAND    = 5'b01001;
    localparam logic [4:0] OP_NOR     = 5'b01010;
    localparam logic [4:0] OP_NOT     = 5'b01011;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

    state_t                  state_reg, state_next;
    logic [DATA_W-1:0]       gpr_reg [NREGS];
    logic [DATA_W-1:0]       rd_view [32];
    logic [4:0]              opc_reg, rdst_reg;
    logic [DATA_W-1:0]       op1_reg, op2_reg, mplier_reg, sgpr_reg;
    logic [2*DATA_W-1:0]     acc_reg, mcand_reg;
    logic [CW-1:0]           cnt_reg;
    logic [3:0]              flags_reg;
    logic                    done_reg, err_reg;

    // 32-entry read view so any 5-bit index is legal; entries beyond NREGS read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_view
            if (gi < NREGS) begin : g_in
                assign rd_view[gi] = gpr_reg[gi];
            end else begin : g_out
                assign rd_view[gi] = '0;
            end
        end
    endgenerate

    logic [4:0]        in_opc, in_rdst, in_rs1, in_rs2;
    logic              in_imm, accept;
    logic [15:0]       in_isrc;
    logic [DATA_W-1:0] op1_in, op2_in;

    assign in_opc  = instr[31:27];
    assign in_rdst = instr[26:22];
    assign in_rs1  = instr[21:17];
    assign in_imm  = instr[16];
    assign in_rs2  = instr[15:11];
    assign in_isrc = instr[15:0];

    assign op2_in = in_imm ? DATA_W'(in_isrc) : rd_view[in_rs2];
    assign op1_in = (in_imm && (in_opc == OP_MOV || in_opc == OP_NOT)) ? op2_in : rd_view[in_rs1];
    assign accept = instr_valid && instr_ready;

    assign dbg_rdata = rd_view[dbg_raddr];
    assign done      = done_reg;
    assign err       = err_reg;
    assign flags     = flags_reg;
    assign sgpr      = sgpr_reg;

    // Single-cycle ALU on the captured operands
    logic [DATA_W:0]   sum_w;
    logic [DATA_W-1:0] diff_w, alu_res;
    logic              alu_c, alu_v, alu_legal;

    assign sum_w  = {1'b0, op1_reg} + {1'b0, op2_reg};
    assign diff_w = op1_reg - op2_reg;

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        case (opc_reg)
            OP_MOVSGPR: alu_res = sgpr_reg;
            OP_MOV:     alu_res = op1_reg;
            OP_ADD: begin
                alu_res = sum_w[DATA_W-1:0];
                alu_c   = sum_w[DATA_W];
                alu_v   = (op1_reg[DATA_W-1] == op2_reg[DATA_W-1]) &&
                          (sum_w[DATA_W-1] != op1_reg[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff_w;
                alu_c   = op1_reg < op2_reg;
                alu_v   = (op1_reg[DATA_W-1] != op2_reg[DATA_W-1]) &&
                          (diff_w[DATA_W-1] != op1_reg[DATA_W-1]);
            end
            OP_OR:      alu_res = op1_reg | op2_reg;
            OP_AND:     alu_res = op1_reg & op2_reg;
            OP_XOR:     alu_res = op1_reg ^ op2_reg;
            OP_XNOR:    alu_res = ~(op1_reg ^ op2_reg);
            OP_NAND:    alu_res = ~(op1_reg & op2_reg);
            OP_NOR:     alu_res = ~(op1_reg | op2_reg);
            OP_NOT:     alu_res = ~op1_reg;
            default:    alu_legal = 1'b0;
        endcase
    end

    // Commit path shared by EXEC and WB
    logic [DATA_W-1:0] acc_lo, acc_hi, wr_data;
    logic              wr_en, wr_in_range, hi_nz;
    logic [3:0]        flags_new;

    assign acc_lo      = acc_reg[DATA_W-1:0];
    assign acc_hi      = acc_reg[2*DATA_W-1:DATA_W];
    assign hi_nz       = (acc_hi != '0);
    assign wr_in_range = ({1'b0, rdst_reg} < 6'(NREGS));

    always_comb begin
        wr_en     = 1'b0;
        wr_data   = alu_res;
        flags_new = flags_reg;
        if (state_reg == EXEC && alu_legal) begin
            wr_en     = 1'b1;
            flags_new = {alu_res[DATA_W-1], (alu_res == '0), alu_c, alu_v};
        end else if (state_reg == WB) begin
            wr_en     = 1'b1;
            wr_data   = acc_lo;
            flags_new = {acc_lo[DATA_W-1], (acc_lo == '0), hi_nz, hi_nz};
        end
    end

    always_comb begin
        state_next  = state_reg;
        instr_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = (in_opc == OP_MUL) ? MUL : EXEC;
            end
            EXEC:    state_next = IDLE;
            MUL:     if (cnt_reg == '0) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_reg    <= '0;
            rdst_reg   <= '0;
            op1_reg    <= '0;
            op2_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            sgpr_reg   <= '0;
            flags_reg  <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            for (int i = 0; i < NREGS; i++) gpr_reg[i] <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            if (accept) begin
                opc_reg    <= in_opc;
                rdst_reg   <= in_rdst;
                op1_reg    <= op1_in;
                op2_reg    <= op2_in;
                acc_reg    <= '0;
                mcand_reg  <= {{DATA_W{1'b0}}, op1_in};
                mplier_reg <= op2_in;
                cnt_reg    <= CW'(DATA_W - 1);
            end
            if (state_reg == MUL) begin
                if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
            end
            if (state_reg == EXEC && !alu_legal) err_reg <= 1'b1;
            if (wr_en) begin
                flags_reg <= flags_new;
                done_reg  <= 1'b1;
                if (wr_in_range) gpr_reg[rdst_reg[AW-1:0]] <= wr_data;
            end
            if (state_reg == WB) sgpr_reg <= acc_hi;
        end
    end

endmodule

// File: tb/tb_gpr_exec_unit.sv
// Scoreboard bench for gpr_exec_unit: two instances (16-bit/32 regs and 32-bit/8 regs)
// driven by directed and random instructions against an arithmetic reference model.
module tb_gpr_exec_unit;
    localparam logic [4:0] OP_MOVSGPR = 5'd0, OP_MOV = 5'd1, OP_ADD = 5'd2, OP_SUB = 5'd3;
    localparam logic [4:0] OP_MUL = 5'd4, OP_OR = 5'd5, OP_AND = 5'd6, OP_XOR = 5'd7;
    localparam logic [4:0] OP_XNOR = 5'd8, OP_NAND = 5'd9, OP_NOR = 5'd10, OP_NOT = 5'd11;
    localparam logic [4:0] OP_BAD = 5'd31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        valid_v [2];
    logic [31:0] instr_v [2];
    logic        ready_v [2];
    logic        done_v  [2];
    logic        err_v   [2];
    logic [3:0]  flags_v [2];
    logic [4:0]  dbg_addr_v [2];
    logic [31:0] sgpr_v [2];
    logic [31:0] dbg_v  [2];
    logic [15:0] a_sgpr, a_dbg;
    logic [31:0] b_sgpr, b_dbg;

    assign sgpr_v[0] = {16'h0, a_sgpr};
    assign dbg_v[0]  = {16'h0, a_dbg};
    assign sgpr_v[1] = b_sgpr;
    assign dbg_v[1]  = b_dbg;

    gpr_exec_unit #(.DATA_W(16), .NREGS(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(valid_v[0]), .instr_ready(ready_v[0]), .instr(instr_v[0]),
        .done(done_v[0]), .err(err_v[0]), .flags(flags_v[0]), .sgpr(a_sgpr),
        .dbg_raddr(dbg_addr_v[0]), .dbg_rdata(a_dbg)
    );

    gpr_exec_unit #(.DATA_W(32), .NREGS(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(valid_v[1]), .instr_ready(ready_v[1]), .instr(instr_v[1]),
        .done(done_v[1]), .err(err_v[1]), .flags(flags_v[1]), .sgpr(b_sgpr),
        .dbg_raddr(dbg_addr_v[1]), .dbg_rdata(b_dbg)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          inst;
        logic [4:0]  op;
        bit          is_err;
        logic [4:0]  rdst;
        logic [31:0] rd_val;
        logic [31:0] sgpr;
        logic [3:0]  flags;
        int          exp_cyc;
    } exp_t;
    exp_t sb_q [$];

    // Reference model state
    logic [31:0] gpr_m [2][32];
    logic [31:0] sgpr_m [2];
    logic [3:0]  flags_m [2];
    int          wid [2] = '{16, 32};
    int          nrg [2] = '{32, 8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ri(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic logic [31:0] rr(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'd0};
    endfunction

    function automatic longint unsigned rdm(input int k, input logic [4:0] a);
        return (int'(a) < nrg[k]) ? 64'(gpr_m[k][a]) : 64'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) gpr_m[k][i] = '0;
            sgpr_m[k]  = '0;
            flags_m[k] = '0;
        end
    endtask

    task automatic model_exec(input int k, input logic [31:0] ins, output exp_t e);
        logic [4:0] op, rd;
        longint unsigned mask, a, b, r, full, hi;
        bit c, v, legal, imm;
        int w;
        w = wid[k];
        mask = (64'd1 << w) - 64'd1;
        op = ins[31:27];
        rd = ins[26:22];
        imm = ins[16];
        a = rdm(k, ins[21:17]);
        b = imm ? 64'(ins[15:0]) : rdm(k, ins[15:11]);
        r = 0; hi = 0; c = 0; v = 0; legal = 1;
        case (op)
            OP_MOVSGPR: r = 64'(sgpr_m[k]);
            OP_MOV:     r = imm ? b : a;
            OP_ADD: begin
                full = a + b; r = full & mask; c = (full >> w) != 0;
                v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
            end
            OP_SUB: begin
                r = (a - b) & mask; c = a < b;
                v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
            end
            OP_MUL: begin
                full = a * b; r = full & mask; hi = (full >> w) & mask;
                c = hi != 0; v = c;
            end
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b) & mask;
            OP_NAND: r = ~(a & b) & mask;
            OP_NOR:  r = ~(a | b) & mask;
            OP_NOT:  r = ~(imm ? b : a) & mask;
            default: legal = 0;
        endcase
        if (legal) begin
            flags_m[k] = {r[w-1], (r == 0), c, v};
            if (op == OP_MUL) sgpr_m[k] = hi[31:0];
            if (int'(rd) < nrg[k]) gpr_m[k][rd] = r[31:0];
        end
        e.inst    = k;
        e.op      = op;
        e.is_err  = !legal;
        e.rdst    = rd;
        e.rd_val  = rdm(k, rd)[31:0];
        e.sgpr    = sgpr_m[k];
        e.flags   = flags_m[k];
        e.exp_cyc = (op == OP_MUL) ? w + 1 : 1;
    endtask

    // Present ins, wait for ready, record the expectation at the accept edge.
    task automatic issue(input int k, input logic [31:0] ins, input bit keep);
        exp_t e;
        int guard;
        @(negedge clk);
        instr_v[k] = ins;
        valid_v[k] = 1'b1;
        guard = 0;
        while (!ready_v[k] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_v[k]) begin
            checks++; errors++;
            $display("FAIL issue_timeout: inst %0d ready stuck at 0, required 1", k);
            valid_v[k] = 1'b0;
            return;
        end
        model_exec(k, ins, e);
        e.exp_cyc = cyc + 1 + e.exp_cyc;
        sb_q.push_back(e);
        $display("issue inst=%0d op=%0d instr=0x%08h expect rd[%0d]=0x%0h flags=%b", k, e.op, ins,
                 e.rdst, e.rd_val, e.flags);
        @(negedge clk);
        if (!keep) valid_v[k] = 1'b0;
    endtask

    task automatic reset_mid_mul(input int k);
        issue(k, ri(OP_MOV, 5'd3, 5'd0, 16'h0055), 1'b0);
        issue(k, ri(OP_MOV, 5'd1, 5'd0, 16'hC003), 1'b0);
        issue(k, rr(OP_MUL, 5'd3, 5'd1, 5'd1), 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        sb_q.delete();
        #1;
        chk("rst_ready", 32'(ready_v[k]), 32'd1);
        chk("rst_done", 32'(done_v[k]), 32'd0);
        chk("rst_flags", 32'(flags_v[k]), 32'd0);
        chk("rst_sgpr", sgpr_v[k], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(k, rr(OP_MOV, 5'd6, 5'd3, 5'd0), 1'b0);
        issue(k, rr(OP_MOVSGPR, 5'd7, 5'd0, 5'd0), 1'b0);
    endtask

    task automatic random_run(input int k, input int n);
        logic [31:0] ins;
        for (int i = 0; i < n; i++) begin
            ins = $urandom;
            ins[31:27] = 5'($urandom_range(0, 15));
            if (k == 1) begin
                ins[26:22] = 5'($urandom_range(0, 11));
                ins[21:17] = 5'($urandom_range(0, 11));
                ins[15:11] = 5'($urandom_range(0, 11));
            end
            issue(k, ins, 1'b0);
        end
    endtask

    // Monitor: pop and compare whenever an instance reports completion.
    initial begin
        exp_t e;
        dbg_addr_v[0] = '0;
        dbg_addr_v[1] = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst_n && (done_v[k] || err_v[k])) begin
                    chk("done_err_exclusive", 32'(done_v[k] & err_v[k]), 32'd0);
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: inst %0d done=%0b err=%0b with no pending instruction",
                                 k, done_v[k], err_v[k]);
                    end else begin
                        e = sb_q.pop_front();
                        dbg_addr_v[k] = e.rdst;
                        #1;
                        chk("instance", 32'(k), 32'(e.inst));
                        chk("err_pulse", 32'(err_v[k]), 32'(e.is_err));
                        chk("commit_cycle", 32'(cyc), 32'(e.exp_cyc));
                        chk("flags", 32'(flags_v[k]), 32'(e.flags));
                        chk("sgpr", sgpr_v[k], e.sgpr);
                        chk("gpr_rdst", dbg_v[k], e.rd_val);
                        $display("commit inst=%0d op=%0d rd[%0d]=0x%0h flags=%b sgpr=0x%0h", k, e.op,
                                 e.rdst, dbg_v[k], flags_v[k], sgpr_v[k]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        valid_v[0] = 1'b0; valid_v[1] = 1'b0;
        instr_v[0] = '0;   instr_v[1] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ready", 32'(ready_v[k]), 32'd1);
            chk("reset_done", 32'(done_v[k]), 32'd0);
            chk("reset_err", 32'(err_v[k]), 32'd0);
            chk("reset_flags", 32'(flags_v[k]), 32'd0);
            chk("reset_sgpr", sgpr_v[k], 32'd0);
        end
        rst_n = 1'b1;

        issue(0, ri(OP_MOV, 5'd1, 5'd0, 16'h1234), 1'b0);
        issue(0, ri(OP_MOV, 5'd1, 5'd0, 16'hFFFF), 1'b0);
        issue(0, ri(OP_ADD, 5'd2, 5'd1, 16'h0001), 1'b0);
        issue(0, ri(OP_SUB, 5'd3, 5'd2, 16'h0001), 1'b0);
        issue(0, ri(OP_MOV, 5'd4, 5'd0, 16'h7FFF), 1'b0);
        issue(0, ri(OP_ADD, 5'd5, 5'd4, 16'h0001), 1'b0);
        issue(0, ri(OP_MOV, 5'd1, 5'd0, 16'h1234), 1'b0);
        issue(0, ri(OP_MOV, 5'd2, 5'd0, 16'h5678), 1'b0);
        issue(0, rr(OP_MUL, 5'd3, 5'd1, 5'd2), 1'b1);
        issue(0, rr(OP_MOVSGPR, 5'd4, 5'd0, 5'd0), 1'b0);
        issue(0, rr(OP_ADD, 5'd13, 5'd3, 5'd4), 1'b0);
        issue(0, ri(OP_MOV, 5'd1, 5'd0, 16'hF0F0), 1'b0);
        issue(0, ri(OP_OR,   5'd6,  5'd1, 16'h0FF0), 1'b0);
        issue(0, ri(OP_AND,  5'd7,  5'd1, 16'h0FF0), 1'b0);
        issue(0, ri(OP_XOR,  5'd8,  5'd1, 16'h0FF0), 1'b0);
        issue(0, ri(OP_XNOR, 5'd9,  5'd1, 16'h0FF0), 1'b0);
        issue(0, ri(OP_NAND, 5'd10, 5'd1, 16'h0FF0), 1'b0);
        issue(0, ri(OP_NOR,  5'd11, 5'd1, 16'h0FF0), 1'b0);
        issue(0, rr(OP_NOT,  5'd1,  5'd1, 5'd0), 1'b0);
        issue(0, ri(OP_BAD,  5'd2,  5'd1, 16'h0003), 1'b0);
        issue(0, rr(OP_SUB,  5'd12, 5'd2, 5'd1), 1'b0);
        random_run(0, 120);
        reset_mid_mul(0);

        issue(1, ri(OP_MOV, 5'd9, 5'd0, 16'hABCD), 1'b0);
        issue(1, ri(OP_ADD, 5'd1, 5'd9, 16'h0005), 1'b0);
        issue(1, ri(OP_MOV, 5'd2, 5'd0, 16'hFFFF), 1'b0);
        issue(1, rr(OP_MUL, 5'd3, 5'd2, 5'd2), 1'b0);
        issue(1, rr(OP_MUL, 5'd4, 5'd3, 5'd3), 1'b0);
        issue(1, rr(OP_MOVSGPR, 5'd5, 5'd0, 5'd0), 1'b0);
        random_run(1, 60);
        reset_mid_mul(1);

        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d instructions never completed, required 0", sb_q.size());
        end
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
